fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single FIFO write port among NUM_REQ requesters using round-robin arbitration.
//  Each requester has its own valid/ready handshake. Granted data is forwarded as a one-cycle fifo_wr_en pulse.
//  The block then waits for the FIFO's wr_ack, or its overflow, and reports the outcome to the owning requester.
//  Sits between the SPI/RAM-side producers and the FIFO write interface.
// PARAMETERS
//  NUM_REQ      2    number of requesters (2..8)
//  DATA_W       16   FIFO data width
//  ACK_TIMEOUT  4    cycles in WAIT_ACK before declaring an ack error (>=2)
// PORTS
//  clk           in   1               rising-edge clock
//  rst           in   1               synchronous, active-high reset
//  req_valid     in   NUM_REQ         requester i has a word to write
//  req_data      in   NUM_REQ*DATA_W  word of requester i at slice [i*DATA_W +: DATA_W]
//  req_ready     out  NUM_REQ         combinational; one-hot; word i accepted at this edge
//  req_done      out  NUM_REQ         registered 1-cycle pulse: requester's word acked by FIFO
//  req_err       out  NUM_REQ         registered 1-cycle pulse: overflow or ack timeout on requester's word
//  fifo_wr_en    out  1               registered write strobe to FIFO
//  fifo_din      out  DATA_W          registered write data; valid while fifo_wr_en=1
//  fifo_full     in   1               FIFO full flag
//  fifo_wr_ack   in   1               FIFO write acknowledge (arrives 1-2 cycles after wr_en)
//  fifo_overflow in   1               FIFO overflow flag (write attempted while full)
//  ovf_cnt       out  8               saturating count of overflow/timeout errors
//  busy          out  1               state != IDLE
// BEHAVIOUR
//  Reset (synchronous, rst=1 at posedge):
//   - state=IDLE, rr_ptr=0, owner=0.
//   - fifo_wr_en=0, fifo_din=0, req_done=0, req_err=0, ovf_cnt=0, tmo=0.
//   - req_ready=0 while rst=1.
//   - A reset taken mid-transaction drops the word with no done/err pulse.
//  FSM states: IDLE, WRITE, WAIT_ACK. At most one write is outstanding.
//  IDLE:
//   - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - If any valid and fifo_full=0: req_ready[winner]=1; latch owner=winner and fifo_din=req_data[winner].
//     Set fifo_wr_en=1 next cycle and go to WRITE.
//   - If fifo_full=1: req_ready stays 0 and the FSM stays in IDLE; no word is ever issued into a full FIFO.
//  WRITE:
//   - fifo_wr_en is high for exactly this one cycle.
//   - Next edge: fifo_wr_en=0, tmo=0, go to WAIT_ACK.
//  WAIT_ACK (checks apply from the WRITE-state cycle onward, covering 1-2 cycle ack latency):
//   - fifo_wr_ack=1: req_done[owner] pulses, rr_ptr=(owner+1)%NUM_REQ, go to IDLE.
//   - else fifo_overflow=1: req_err[owner] pulses, ovf_cnt++, rr_ptr advances, go to IDLE.
//   - else tmo==ACK_TIMEOUT-1: same as the overflow case.
//   - otherwise tmo++.
//   - If ack and overflow arrive together, ack wins.
//  Throughput: at most one word per 3 cycles (IDLE->WRITE->WAIT_ACK).
//  Fairness: rr_ptr advances only on completion, so a requester holding valid is served within NUM_REQ transactions.
//  req_valid may drop before ready without penalty; data must be stable while valid=1.
//  ovf_cnt saturates at 8'hFF; no wrap.
//  Index arithmetic: rr_ptr and owner are $clog2(NUM_REQ) bits wide; wrap is explicit modulo NUM_REQ.
// STRUCTURE
//  Package fifo_arb_pkg: typedef enum logic[1:0] {IDLE,WRITE,WAIT_ACK} arb_state_t; OVF_CNT_W=8.
//  Sub-module rr_pick: combinational round-robin picker.
//   - Inputs: req vector, rr_ptr. Outputs: one-hot grant, winner index, any.
//   - Single instance.
//  Top contains the FSM, data/owner registers, timeout and error counters.
// TESTING (NUM_REQ=2, DATA_W=16, ACK_TIMEOUT=4; FIFO model acks 1 cycle after wr_en)
//  1 Reset: rst=1 for 2 cycles with req_valid=2'b11.
//    -> all outputs 0, req_ready=0; first grant after release goes to requester 0.
//  2 Single write: req0 valid, data 16'hA5A5.
//    -> ready[0] at t, fifo_wr_en=1/din=A5A5 at t+1, wr_ack at t+2, req_done[0] at t+3.
//  3 Contention: both valid continuously, data 0x1111/0x2222.
//    -> FIFO receives 1111,2222,1111,2222; each done pulse alternates owner.
//  4 Full stall: fifo_full=1 with req1 valid for 10 cycles.
//    -> req_ready=0 and fifo_wr_en=0 throughout; on full=0, issue within 2 cycles.
//  5 Overflow: model raises fifo_overflow instead of ack for req1's write.
//    -> req_err[1] pulses, ovf_cnt=1, no req_done; next grant goes to req0.
//  6 Timeout/reset: model never acks.
//    -> req_err[owner] after 4 WAIT_ACK cycles. Repeat and assert rst in WAIT_ACK: IDLE next cycle, no pulses.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_t;

  localparam int OVF_CNT_W = 8;

  // Error counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (v == '1) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshakes plus the FIFO write port, bundled for the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_din;
  logic                      fifo_full;
  logic                      fifo_wr_ack;
  logic                      fifo_overflow;

  // master: the arbiter; slave: requesters and FIFO seen from outside.
  modport master (
    input  req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    output req_ready, req_done, req_err, fifo_wr_en, fifo_din
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  req_ready, req_done, req_err, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] src;
  logic               found;

  // Requests at or above the pointer take priority; otherwise wrap to the bottom.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign upper[gi] = req[gi] && (gi >= int'(rr_ptr));
    end
  endgenerate

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    any   = |req;
    src   = (|upper) ? upper : req;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (src[k] && !found) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port; one outstanding write, outcome reported per requester.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_wr_arbiter_if.master    bus,
  output logic [OVF_CNT_W-1:0] ovf_cnt,
  output logic                 busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic                 wr_en_q, wr_en_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic                 issue;
  logic                 finish_ok;
  logic                 finish_err;
  logic [IDX_W-1:0]     owner_next;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [DATA_W-1:0]    req_word [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Pointer moves past the owner only once its word has resolved.
  assign owner_next = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    din_d      = din_q;
    wr_en_d    = 1'b0;
    tmo_d      = tmo_q;
    done_d     = '0;
    err_d      = '0;
    ovf_cnt_d  = ovf_cnt_q;
    issue      = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any && !bus.fifo_full && !rst) begin
          issue   = 1'b1;
          owner_d = pick_idx;
          din_d   = req_word[pick_idx];
          wr_en_d = 1'b1;
          state_d = WRITE;
        end
      end
      // Ack/overflow are already honoured in the strobe cycle.
      WRITE: begin
        tmo_d = '0;
        if (bus.fifo_wr_ack) begin
          finish_ok = 1'b1;
        end else if (bus.fifo_overflow) begin
          finish_err = 1'b1;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.fifo_wr_ack) begin
          finish_ok = 1'b1;
        end else if (bus.fifo_overflow || (tmo_q == TMO_LAST)) begin
          finish_err = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish_ok || finish_err) begin
      rr_ptr_d = owner_next;
      state_d  = IDLE;
    end
    if (finish_ok) begin
      done_d = NUM_REQ'(1) << owner_q;
    end
    if (finish_err) begin
      err_d     = NUM_REQ'(1) << owner_q;
      ovf_cnt_d = sat_inc(ovf_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      din_q     <= '0;
      wr_en_q   <= 1'b0;
      tmo_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      din_q     <= din_d;
      wr_en_q   <= wr_en_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign bus.req_ready  = issue ? pick_grant : '0;
  assign bus.req_done   = done_q;
  assign bus.req_err    = err_q;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_din   = din_q;
  assign ovf_cnt        = ovf_cnt_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios plus randomized traffic, checked against a transaction-level model.
module tb_fifo_wr_arbiter;
  localparam int N   = 2;
  localparam int DW  = 16;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ovf_cnt;
  logic       busy;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus_if ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ACK_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .ovf_cnt (ovf_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one outstanding word, its age in cycles since the grant edge.
  bit            m_out = 0;
  int            m_owner = 0;
  int            m_age = 0;
  int            m_rr = 0;
  int            m_cnt = 0;
  logic [DW-1:0] m_din = '0;
  logic [N-1:0]  m_grant = '0;
  logic [N-1:0]  exp_done = '0;
  logic [N-1:0]  exp_err = '0;
  bit            exp_wr_en = 0;

  // Stimulus knobs and FIFO responder state.
  bit            random_mode = 0;
  bit            k_rst = 1;
  int            left [N];
  logic [DW-1:0] k_data [N];
  bit            k_full = 0;
  int            k_mode = 0;   // 0 ack+1, 1 ack+2, 2 overflow, 3 silent, 4 ack and overflow
  bit            wr_seen = 0;
  bit            pend2 = 0;
  logic [DW-1:0] got_q [$];
  int            done_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rr_winner(input logic [N-1:0] v, input int rr);
    logic [N-1:0] g;
    g = '0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr + k) % N;
      if (v[i]) begin
        g[i] = 1'b1;
        break;
      end
    end
    return g;
  endfunction

  function automatic logic [N-1:0] exp_ready_now();
    if (rst || m_out || bus_if.fifo_full) return '0;
    return rr_winner(bus_if.req_valid, m_rr);
  endfunction

  task automatic model_update();
    bit fin;
    bit bad;
    m_grant   = exp_ready_now();
    exp_done  = '0;
    exp_err   = '0;
    exp_wr_en = 0;
    fin = 0;
    bad = 0;
    if (rst) begin
      m_out = 0;
      m_rr  = 0;
      m_cnt = 0;
    end else if (!m_out) begin
      if (m_grant != '0) begin
        m_out     = 1;
        m_age     = 1;
        exp_wr_en = 1;
        for (int i = 0; i < N; i++)
          if (m_grant[i]) begin
            m_owner = i;
            m_din   = bus_if.req_data[i*DW +: DW];
          end
      end
    end else begin
      if (bus_if.fifo_wr_ack) fin = 1;
      else if (bus_if.fifo_overflow || m_age == TMO + 1) begin
        fin = 1;
        bad = 1;
      end else m_age++;
      if (fin) begin
        m_out = 0;
        if (bad) begin
          exp_err[m_owner] = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          exp_done[m_owner] = 1'b1;
        end
        m_rr = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic drive();
    int mode;
    if (random_mode) begin
      for (int i = 0; i < N; i++) begin
        if (m_grant[i] || !bus_if.req_valid[i]) begin
          bus_if.req_valid[i]        = ($urandom_range(0, 2) != 0);
          bus_if.req_data[i*DW +: DW] = DW'($urandom);
        end else if ($urandom_range(0, 9) == 0) begin
          bus_if.req_valid[i] = 1'b0;
        end
      end
      bus_if.fifo_full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 399) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: mode = 0;
        4, 5:       mode = 1;
        6, 7:       mode = 2;
        8:          mode = 4;
        default:    mode = 3;
      endcase
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_grant[i] && left[i] > 0) left[i]--;
        bus_if.req_valid[i]        = (left[i] > 0);
        bus_if.req_data[i*DW +: DW] = k_data[i];
      end
      bus_if.fifo_full = k_full;
      rst  = k_rst;
      mode = k_mode;
    end
    bus_if.fifo_wr_ack   = (wr_seen && (mode == 0 || mode == 4)) || pend2;
    pend2                = wr_seen && (mode == 1);
    bus_if.fifo_overflow = wr_seen && (mode == 2 || mode == 4);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    drive();
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [N-1:0] er;
    er = exp_ready_now();
    chk("ready", 32'(bus_if.req_ready), 32'(er));
    chk("wr_en", 32'(bus_if.fifo_wr_en), 32'(exp_wr_en));
    if (exp_wr_en) chk("din", 32'(bus_if.fifo_din), 32'(m_din));
    chk("done", 32'(bus_if.req_done), 32'(exp_done));
    chk("err", 32'(bus_if.req_err), 32'(exp_err));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_out));
    if (bus_if.fifo_wr_en) got_q.push_back(bus_if.fifo_din);
    for (int i = 0; i < N; i++)
      if (bus_if.req_done[i]) done_q.push_back(i);
    if (exp_done != '0 || exp_err != '0)
      $display("txn owner=%0d data=%h result=%s ovf_cnt=%0d", m_owner, m_din,
               (exp_done != '0) ? "done" : "err", m_cnt);
    wr_seen = bus_if.fifo_wr_en;
  end

  initial begin
    logic [DW-1:0] exp_seq [4];
    int            exp_own [4];
    exp_seq = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
    exp_own = '{0, 1, 0, 1};

    // Reset with both requesters valid.
    left   = '{1, 1};
    k_data = '{16'hA5A5, 16'h2222};
    k_rst  = 1;
    drive();
    step();
    chk("rst_ready", 32'(bus_if.req_ready), 32'h0);
    chk("rst_wr_en", 32'(bus_if.fifo_wr_en), 32'h0);
    chk("rst_done_err", 32'({bus_if.req_done, bus_if.req_err}), 32'h0);
    chk("rst_ovf_busy", 32'({ovf_cnt, busy}), 32'h0);
    step();
    chk("rst_ready2", 32'(bus_if.req_ready), 32'h0);

    // Single write A5A5 from requester 0, first grant after release.
    k_rst = 0;
    step();
    chk("t2_ready", 32'(bus_if.req_ready), 32'h1);
    step();
    chk("t2_wr_en", 32'(bus_if.fifo_wr_en), 32'h1);
    chk("t2_din", 32'(bus_if.fifo_din), 32'hA5A5);
    step();
    step();
    chk("t2_done", 32'(bus_if.req_done), 32'h1);
    chk("t2_err", 32'(bus_if.req_err), 32'h0);
    repeat (6) step();

    // Contention: two words each, owners must alternate.
    got_q.delete();
    done_q.delete();
    left   = '{2, 2};
    k_data = '{16'h1111, 16'h2222};
    repeat (16) step();
    chk("t3_words", 32'(got_q.size()), 32'd4);
    chk("t3_dones", 32'(done_q.size()), 32'd4);
    if (got_q.size() == 4)
      for (int j = 0; j < 4; j++) chk("t3_din_order", 32'(got_q[j]), 32'(exp_seq[j]));
    if (done_q.size() == 4)
      for (int j = 0; j < 4; j++) chk("t3_done_owner", 32'(done_q[j]), 32'(exp_own[j]));

    // Full stall with requester 1 waiting.
    k_full  = 1;
    left[1] = 1;
    repeat (10) begin
      step();
      chk("t4_ready_full", 32'(bus_if.req_ready), 32'h0);
      chk("t4_wr_en_full", 32'(bus_if.fifo_wr_en), 32'h0);
    end
    k_full = 0;
    step();
    chk("t4_ready", 32'(bus_if.req_ready), 32'h2);
    step();
    chk("t4_wr_en", 32'(bus_if.fifo_wr_en), 32'h1);
    repeat (4) step();

    // Overflow on requester 1's word.
    k_mode  = 2;
    left[1] = 1;
    step();
    chk("t5_ready", 32'(bus_if.req_ready), 32'h2);
    step();
    step();
    k_mode = 0;
    left   = '{1, 1};
    step();
    chk("t5_err", 32'(bus_if.req_err), 32'h2);
    chk("t5_done", 32'(bus_if.req_done), 32'h0);
    chk("t5_ovf_cnt", 32'(ovf_cnt), 32'd1);
    chk("t5_next_grant", 32'(bus_if.req_ready), 32'h1);
    repeat (8) step();

    // Ack timeout, then reset during WAIT_ACK.
    k_mode  = 3;
    left[0] = 1;
    step();
    chk("t6_ready", 32'(bus_if.req_ready), 32'h1);
    repeat (5) step();
    chk("t6_err_early", 32'(bus_if.req_err), 32'h0);
    chk("t6_busy", 32'(busy), 32'h1);
    step();
    chk("t6_err", 32'(bus_if.req_err), 32'h1);
    chk("t6_idle", 32'(busy), 32'h0);
    chk("t6_ovf_cnt", 32'(ovf_cnt), 32'd2);
    left[1] = 1;
    step();
    chk("t6_ready2", 32'(bus_if.req_ready), 32'h2);
    step();
    step();
    k_rst = 1;
    step();
    chk("t6_rst_ready", 32'(bus_if.req_ready), 32'h0);
    k_rst = 0;
    step();
    chk("t6_rst_idle", 32'(busy), 32'h0);
    chk("t6_rst_ovf", 32'(ovf_cnt), 32'd0);
    repeat (6) begin
      step();
      chk("t6_no_pulse", 32'({bus_if.req_done, bus_if.req_err}), 32'h0);
    end

    // Randomized traffic, full, response kinds and occasional reset.
    k_mode      = 0;
    random_mode = 1;
    repeat (3000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
